// File: rtl/sram_test_pkg.sv
// Shared types and constants for the SRAM March C- tester: element/op/state
// encodings and the per-element direction and data polarity table.
package sram_test_pkg;

  localparam int ERR_W     = 16;
  localparam int NUM_ELEMS = 6;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_e;
  typedef enum logic       {OP_R, OP_W} march_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} fsm_state_e;

  typedef struct packed {
    logic desc;    // addresses walked from DEPTH-1 down to 0
    logic has_rd;
    logic has_wr;
    logic rd_one;  // read expects ~background
    logic wr_one;  // write stores ~background
  } elem_info_t;

  function automatic elem_info_t elem_info(input march_elem_e e);
    elem_info_t i;
    i = '0;
    case (e)
      E0: i.has_wr = 1'b1;
      E1: begin i.has_rd = 1'b1; i.has_wr = 1'b1; i.wr_one = 1'b1; end
      E2: begin i.has_rd = 1'b1; i.has_wr = 1'b1; i.rd_one = 1'b1; end
      E3: begin i.desc = 1'b1; i.has_rd = 1'b1; i.has_wr = 1'b1; i.wr_one = 1'b1; end
      E4: begin i.desc = 1'b1; i.has_rd = 1'b1; i.has_wr = 1'b1; i.rd_one = 1'b1; end
      E5: i.has_rd = 1'b1;
      default: ;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/sram_march_tester_if.sv
// Control/status bundle of the SRAM March tester. With SRAM_TEST_INJECT_EN
// defined it also carries the inject request used to force bank-0 failures.
interface sram_march_tester_if import sram_test_pkg::*; #(
  parameter int NUM_BANKS = 3,
  parameter int ADDR_W    = 10
) ();
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [NUM_BANKS-1:0] fail_mask;
  logic [ADDR_W-1:0]    fail_addr;
  logic [2:0]           fail_elem;
  logic [ERR_W-1:0]     err_count;
`ifdef SRAM_TEST_INJECT_EN
  logic                 inject;

  modport master (output start, inject,
                  input  busy, done, pass, fail_mask, fail_addr, fail_elem, err_count);
  modport slave  (input  start, inject,
                  output busy, done, pass, fail_mask, fail_addr, fail_elem, err_count);
`else
  modport master (output start,
                  input  busy, done, pass, fail_mask, fail_addr, fail_elem, err_count);
  modport slave  (input  start,
                  output busy, done, pass, fail_mask, fail_addr, fail_elem, err_count);
`endif
endinterface

// File: rtl/RM_IHPSG13_1P_1024x32_c2_bm_bist.sv
// Behavioural view of the IHP 1024x32 single-port SRAM with bit mask and
// BIST mux; one-cycle registered read. Swap for the foundry view in synthesis.
module RM_IHPSG13_1P_1024x32_c2_bm_bist (
  input  logic        A_CLK,
  input  logic        A_MEN,
  input  logic        A_WEN,
  input  logic        A_REN,
  input  logic [9:0]  A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic        A_DLY,
  output logic [31:0] A_DOUT,
  input  logic [31:0] A_BM,
  input  logic        A_BIST_CLK,
  input  logic        A_BIST_EN,
  input  logic        A_BIST_MEN,
  input  logic        A_BIST_WEN,
  input  logic        A_BIST_REN,
  input  logic [9:0]  A_BIST_ADDR,
  input  logic [31:0] A_BIST_DIN,
  input  logic [31:0] A_BIST_BM
);
  // NOTE: the array has no reset; real SRAM powers up with arbitrary content.
  logic [31:0] mem [0:1023];
  logic        men, wen, ren;
  logic [9:0]  addr;
  logic [31:0] din, bm;
  logic        unused_ok;

  assign men  = A_BIST_EN ? A_BIST_MEN  : A_MEN;
  assign wen  = A_BIST_EN ? A_BIST_WEN  : A_WEN;
  assign ren  = A_BIST_EN ? A_BIST_REN  : A_REN;
  assign addr = A_BIST_EN ? A_BIST_ADDR : A_ADDR;
  assign din  = A_BIST_EN ? A_BIST_DIN  : A_DIN;
  assign bm   = A_BIST_EN ? A_BIST_BM   : A_BM;
  assign unused_ok = &{1'b0, A_DLY, A_BIST_CLK};

  always @(posedge A_CLK) begin
    if (men && wen) mem[addr] <= (mem[addr] & ~bm) | (din & bm);
    if (men && ren) A_DOUT <= mem[addr];
  end
endmodule

// File: rtl/sram_march_seq.sv
// March C- sequencer: run FSM plus element/address/phase counters, and the
// one-cycle read tag that travels alongside each read to the compare stage.
module sram_march_seq import sram_test_pkg::*; #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              clear,
  output logic              men,
  output march_op_e         op,
  output logic [ADDR_W-1:0] addr,
  output logic              wr_one,
  output logic              rd_valid_q,
  output logic              rd_one_q,
  output march_elem_e       rd_elem_q,
  output logic [ADDR_W-1:0] rd_addr_q
);
  fsm_state_e        state, state_n;
  march_elem_e       elem, elem_nxt;
  elem_info_t        info, info_nxt;
  logic [ADDR_W-1:0] addr_r;
  logic              phase, addr_last, op_last, elem_last, run_end;

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    info      = elem_info(elem);
    elem_nxt  = march_elem_e'(elem + 3'd1);
    info_nxt  = elem_info(elem_nxt);
    addr_last = info.desc ? (addr_r == '0) : (addr_r == '1);
    op_last   = !(info.has_rd && info.has_wr) || phase;
    elem_last = (elem == march_elem_e'(NUM_ELEMS - 1));
    op        = (info.has_rd && !phase) ? OP_R : OP_W;
    run_end   = (state == S_RUN) && op_last && addr_last && elem_last;
    state_n   = state;
    clear     = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin state_n = S_RUN; clear = 1'b1; end
      S_RUN:          if (run_end) state_n = S_DRAIN;
      S_DRAIN:        state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || state != S_RUN) begin
      elem   <= E0;
      addr_r <= '0;
      phase  <= 1'b0;
    end else if (!op_last) begin
      phase <= 1'b1;
    end else begin
      phase <= 1'b0;
      if (!addr_last)      addr_r <= info.desc ? addr_r - 1'b1 : addr_r + 1'b1;
      else if (!elem_last) begin
        elem   <= elem_nxt;
        addr_r <= info_nxt.desc ? '1 : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= men && (op == OP_R);
  end

  // NOTE: payload is qualified by rd_valid_q, so only the valid bit needs reset.
  always_ff @(posedge clk) begin
    rd_one_q  <= info.rd_one;
    rd_elem_q <= elem;
    rd_addr_q <= addr_r;
  end

  assign busy   = (state == S_RUN) || (state == S_DRAIN);
  assign done   = (state == S_DONE);
  assign men    = (state == S_RUN);
  assign addr   = addr_r;
  assign wr_one = info.wr_one;
endmodule

// File: rtl/sram_march_tester.sv
// Runs March C- on NUM_BANKS SRAM macros in lockstep and collects results.
// Define SRAM_TEST_INJECT_EN to add an inject input that flips bank-0 bit 0.
module sram_march_tester import sram_test_pkg::*; #(
  parameter int              NUM_BANKS  = 3,
  parameter int              ADDR_W     = 10,
  parameter int              DATA_W     = 32,
  parameter logic [DATA_W-1:0] BG_PATTERN = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  sram_march_tester_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_BANKS + 1);

  logic              busy, done, clear, men, wr_one;
  logic              rd_valid_q, rd_one_q;
  march_op_e         op;
  march_elem_e       rd_elem_q, fail_elem_r;
  logic [ADDR_W-1:0] addr, rd_addr_q, fail_addr_r;
  logic [DATA_W-1:0] din, exp_word, rd_word;
  logic [DATA_W-1:0] dout [NUM_BANKS];
  logic [NUM_BANKS-1:0] mism, fail_mask_r;
  logic [CNT_W-1:0]  n_mism;
  logic [ERR_W-1:0]  err_count_r;
  logic [ERR_W:0]    err_sum;

  sram_march_seq #(.ADDR_W(ADDR_W)) u_seq (
    .clk(clk), .rst(rst), .start(bus.start), .busy(busy), .done(done),
    .clear(clear), .men(men), .op(op), .addr(addr), .wr_one(wr_one),
    .rd_valid_q(rd_valid_q), .rd_one_q(rd_one_q), .rd_elem_q(rd_elem_q),
    .rd_addr_q(rd_addr_q)
  );

  assign din = wr_one ? ~BG_PATTERN : BG_PATTERN;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    RM_IHPSG13_1P_1024x32_c2_bm_bist u_sram (
      .A_CLK(clk), .A_MEN(men), .A_WEN(men && op == OP_W), .A_REN(men && op == OP_R),
      .A_ADDR(addr), .A_DIN(din), .A_DLY(1'b1), .A_DOUT(dout[b]), .A_BM('1),
      .A_BIST_CLK(1'b0), .A_BIST_EN(1'b0), .A_BIST_MEN(1'b0), .A_BIST_WEN(1'b0),
      .A_BIST_REN(1'b0), .A_BIST_ADDR('0), .A_BIST_DIN('0), .A_BIST_BM('0)
    );
  end

  always_comb begin
    exp_word = rd_one_q ? ~BG_PATTERN : BG_PATTERN;
    rd_word  = '0;
    mism     = '0;
    n_mism   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_word = dout[b];
`ifdef SRAM_TEST_INJECT_EN
      if (b == 0) rd_word[0] = rd_word[0] ^ bus.inject;
`endif
      mism[b] = rd_valid_q && (rd_word != exp_word);
      n_mism  = n_mism + CNT_W'(mism[b]);
    end
  end

  assign err_sum = {1'b0, err_count_r} + (ERR_W + 1)'(n_mism);

  // First mismatch is recognised by the mask still being clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      fail_mask_r <= '0;
      fail_addr_r <= '0;
      fail_elem_r <= E0;
      err_count_r <= '0;
    end else if (|mism) begin
      fail_mask_r <= fail_mask_r | mism;
      err_count_r <= err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
      if (fail_mask_r == '0) begin
        fail_addr_r <= rd_addr_q;
        fail_elem_r <= rd_elem_q;
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = done && (fail_mask_r == '0);
  assign bus.fail_mask = fail_mask_r;
  assign bus.fail_addr = fail_addr_r;
  assign bus.fail_elem = fail_elem_r;
  assign bus.err_count = err_count_r;
endmodule

// File: tb/tb_sram_march_tester.sv
// Self-checking bench for sram_march_tester: stuck-at cells are planted in the
// macro arrays and results are compared to hand tables and a march model.
module tb_sram_march_tester;
  localparam int NB    = 3;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BG = 32'h0000_0000;

  typedef struct packed {
    logic        pass;
    logic [2:0]  mask;
    logic [9:0]  addr;
    logic [2:0]  elem;
    logic [15:0] err;
  } res_t;

  typedef struct {
    logic [2:0] fen;
    int         faddr;
    int         fbit;
    bit         fval;
    res_t       exp;
  } vec_t;

  logic clk, rst;
  int   n_checks, n_fail;

  bit [2:0] f_en;
  int       f_addr [NB];
  int       f_bit  [NB];
  bit       f_val  [NB];
  logic [31:0] mdl [NB][DEPTH];

  sram_march_tester_if #(.NUM_BANKS(NB), .ADDR_W(10)) bus ();

  sram_march_tester #(.NUM_BANKS(NB), .ADDR_W(10), .DATA_W(32), .BG_PATTERN(BG)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stuck-at cells: re-impose the stuck value after every clock edge.
  always @(negedge clk) begin
    if (f_en[0]) dut.g_bank[0].u_sram.mem[f_addr[0]][f_bit[0]] = f_val[0];
    if (f_en[1]) dut.g_bank[1].u_sram.mem[f_addr[1]][f_bit[1]] = f_val[1];
    if (f_en[2]) dut.g_bank[2].u_sram.mem[f_addr[2]][f_bit[2]] = f_val[2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_faults(input logic [2:0] en, input int a, input int bt, input bit v);
    f_en = en;
    for (int b = 0; b < NB; b++) begin
      f_addr[b] = a; f_bit[b] = bt; f_val[b] = v;
    end
  endtask

  // March C- applied to plain arrays, op by op, with stuck cells on write.
  task automatic model_run(input bit inj, output res_t r);
    int rd_k [6] = '{-1, 0, 1, 0, 1, 0};
    int wr_k [6] = '{ 0, 1, 0, 1, 0, -1};
    logic [31:0] v;
    bit found;
    int a;
    r = '0;
    found = 1'b0;
    for (int el = 0; el < 6; el++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = (el == 3 || el == 4) ? DEPTH - 1 - i : i;
        if (rd_k[el] >= 0) begin
          for (int b = 0; b < NB; b++) begin
            v = mdl[b][a];
            if (inj && b == 0) v[0] = ~v[0];
            if (v != (rd_k[el] != 0 ? ~BG : BG)) begin
              r.mask[b] = 1'b1;
              r.err     = r.err + 16'd1;
              if (!found) begin
                found = 1'b1; r.addr = 10'(a); r.elem = 3'(el);
              end
            end
          end
        end
        if (wr_k[el] >= 0) begin
          for (int b = 0; b < NB; b++) begin
            v = (wr_k[el] != 0) ? ~BG : BG;
            if (f_en[b] && f_addr[b] == a) v[f_bit[b]] = f_val[b];
            mdl[b][a] = v;
          end
        end
      end
    end
    r.pass = !found;
  endtask

  task automatic do_run(input string tag, input bit pulse_mid, input res_t e);
    int  busy_cyc;
    bit  both;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_start_done_clr"}, 32'(bus.done), 32'd0);
    check({tag, "_start_err_clr"}, 32'(bus.err_count), 32'd0);
    check({tag, "_start_mask_clr"}, 32'(bus.fail_mask), 32'd0);
    busy_cyc = 0;
    both = 1'b0;
    for (int i = 0; i < 20000 && !bus.done; i++) begin
      if (bus.busy) busy_cyc++;
      bus.start = pulse_mid && (i == 100);
      @(negedge clk);
      if (bus.busy && bus.done) both = 1'b1;
    end
    bus.start = 1'b0;
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd10241);
    check({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_done_held"}, 32'(bus.done && !bus.busy), 32'd1);
    check({tag, "_pass"}, 32'(bus.pass), 32'(e.pass));
    check({tag, "_fail_mask"}, 32'(bus.fail_mask), 32'(e.mask));
    check({tag, "_fail_addr"}, 32'(bus.fail_addr), 32'(e.addr));
    check({tag, "_fail_elem"}, 32'(bus.fail_elem), 32'(e.elem));
    check({tag, "_err_count"}, 32'(bus.err_count), 32'(e.err));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_pass"}, 32'(bus.pass), 32'd0);
    check({tag, "_mask"}, 32'(bus.fail_mask), 32'd0);
    check({tag, "_addr"}, 32'(bus.fail_addr), 32'd0);
    check({tag, "_elem"}, 32'(bus.fail_elem), 32'd0);
    check({tag, "_err"}, 32'(bus.err_count), 32'd0);
  endtask

  vec_t vecs [4];
  res_t exp_r;

  initial begin
    vecs[0] = '{3'b000, 0,     0, 1'b0, '{1'b1, 3'b000, 10'h000, 3'd0, 16'd0}};
    vecs[1] = '{3'b010, 'h37,  5, 1'b1, '{1'b0, 3'b010, 10'h037, 3'd1, 16'd3}};
    vecs[2] = '{3'b111, 'h37,  5, 1'b1, '{1'b0, 3'b111, 10'h037, 3'd1, 16'd9}};
    vecs[3] = '{3'b100, 'h3FF, 0, 1'b0, '{1'b0, 3'b100, 10'h3FF, 3'd2, 16'd2}};

    n_checks  = 0;
    n_fail    = 0;
    f_en      = '0;
    bus.start = 1'b0;
`ifdef SRAM_TEST_INJECT_EN
    bus.inject = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    // Abort a faulty run part-way through E2: results must clear at once.
    set_faults(3'b010, 'h37, 5, 1'b1);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (4000) @(negedge clk);
    check("abort_pre_err", 32'(bus.err_count), 32'd1);
    check("abort_pre_mask", 32'(bus.fail_mask), 32'b010);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      set_faults(vecs[v].fen, vecs[v].faddr, vecs[v].fbit, vecs[v].fval);
      do_run($sformatf("vec%0d", v), v == 0, vecs[v].exp);
    end

    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < NB; b++) begin
        f_en[b]   = 1'($urandom_range(0, 1));
        f_addr[b] = int'($urandom_range(0, DEPTH - 1));
        f_bit[b]  = int'($urandom_range(0, 31));
        f_val[b]  = 1'($urandom_range(0, 1));
      end
      model_run(1'b0, exp_r);
      do_run($sformatf("rand%0d", k), 1'b0, exp_r);
    end

`ifdef SRAM_TEST_INJECT_EN
    f_en = '0;
    bus.inject = 1'b1;
    do_run("inject", 1'b0, '{1'b0, 3'b001, 10'h000, 3'd1, 16'd5120});
    bus.inject = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
